// File: rtl/branch_resolve_update_unit.sv
// branch_resolve_update_unit
//
// Back-end counterpart of the fetch-stage jump controller. Collects resolved
// control-flow results from three functional units, detects mispredictions,
// picks the oldest mispredicting result and drives the gshare, JALR and RAS
// update interfaces plus a fetch redirect. All outputs are registered, so they
// appear exactly one cycle after the inputs are sampled.
// After a redirect the unit stays in RECOVER and silently drops results that
// are the same age as the squash point or younger. It stays there until
// flush_done_i arrives in a cycle that has no new winner.
//
// Handshake: there is no backpressure. Every res_valid_k is consumed in the
// cycle it is sampled. Every output pulse is high for exactly one cycle and is
// fire-and-forget.
//
// Ports (k = 0,1,2):
//   clk, reset                 clock, synchronous active-high reset
//   res_*_k                    resolution from FU k (valid, class, pc, outcome,
//                              prediction, targets, ghist, RAS TOS, ROB index)
//   rob_head_i                 ROB head; all ages are measured from it
//   flush_done_i               pipeline flush complete, ends recovery
//   update_prediction_*_k,
//   misprediction_k, update_global_history_k, correct_pc_k
//                              gshare update set (correct_pc_k also for JALR)
//   jalr_update_*_k            JALR predictor update
//   ras_restore_en_o/_tos_o    RAS checkpoint restore for the winner
//   redirect_valid_o/_pc_o     fetch redirect for the winner
//   recovering_o               FSM is in RECOVER (state debug view)
//   perf_branches_o/_mispred_o performance counters
//
// Configuration: define BRU_PERF_CNT_EN to build the saturating performance
// counters. Without it both counter ports are tied to 0.

module branch_resolve_update_unit #(
    parameter int size        = 32,
    parameter int ENTRIES     = 32,
    parameter int INDEX_WIDTH = $clog2(ENTRIES),
    parameter int ROB_IDX_W   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   res_valid_0, res_valid_1, res_valid_2,
    input  logic                   res_is_branch_0, res_is_branch_1, res_is_branch_2,
    input  logic                   res_is_jalr_0, res_is_jalr_1, res_is_jalr_2,
    input  logic [size-1:0]        res_pc_0, res_pc_1, res_pc_2,
    input  logic                   res_taken_0, res_taken_1, res_taken_2,
    input  logic                   res_pred_taken_0, res_pred_taken_1, res_pred_taken_2,
    input  logic [size-1:0]        res_target_0, res_target_1, res_target_2,
    input  logic [size-1:0]        res_pred_target_0, res_pred_target_1, res_pred_target_2,
    input  logic [INDEX_WIDTH:0]   res_ghist_0, res_ghist_1, res_ghist_2,
    input  logic [2:0]             res_ras_tos_0, res_ras_tos_1, res_ras_tos_2,
    input  logic [ROB_IDX_W-1:0]   res_rob_idx_0, res_rob_idx_1, res_rob_idx_2,
    input  logic [ROB_IDX_W-1:0]   rob_head_i,
    input  logic                   flush_done_i,
    output logic [size-1:0]        update_prediction_pc_0, update_prediction_pc_1, update_prediction_pc_2,
    output logic                   update_prediction_valid_o_0, update_prediction_valid_o_1, update_prediction_valid_o_2,
    output logic                   misprediction_0, misprediction_1, misprediction_2,
    output logic [INDEX_WIDTH:0]   update_global_history_0, update_global_history_1, update_global_history_2,
    output logic [size-1:0]        correct_pc_0, correct_pc_1, correct_pc_2,
    output logic                   jalr_update_valid_0, jalr_update_valid_1, jalr_update_valid_2,
    output logic [size-1:0]        jalr_update_prediction_pc_0, jalr_update_prediction_pc_1, jalr_update_prediction_pc_2,
    output logic                   ras_restore_en_o,
    output logic [2:0]             ras_restore_tos_o,
    output logic                   redirect_valid_o,
    output logic [size-1:0]        redirect_pc_o,
    output logic                   recovering_o,
    output logic [31:0]            perf_branches_o,
    output logic [31:0]            perf_mispred_o
);
    localparam int GW = INDEX_WIDTH + 1;

    typedef enum logic {IDLE = 1'b0, RECOVER = 1'b1} state_t;
    state_t state_q, state_d;

    logic [ROB_IDX_W-1:0] squash_idx_q;

    // Slot-indexed views of the three FU result ports.
    logic [2:0]           v, br, jr, tk, ptk;
    logic [size-1:0]      pc [3], tgt [3], ptgt [3];
    logic [GW-1:0]        gh [3];
    logic [2:0]           tos [3];
    logic [ROB_IDX_W-1:0] rob [3];

    always_comb begin
        v   = {res_valid_2, res_valid_1, res_valid_0};
        br  = {res_is_branch_2, res_is_branch_1, res_is_branch_0};
        // A slot flagged as both classes is handled as a branch.
        jr  = {res_is_jalr_2, res_is_jalr_1, res_is_jalr_0} & ~br;
        tk  = {res_taken_2, res_taken_1, res_taken_0};
        ptk = {res_pred_taken_2, res_pred_taken_1, res_pred_taken_0};
        pc[0]   = res_pc_0;          pc[1]   = res_pc_1;          pc[2]   = res_pc_2;
        tgt[0]  = res_target_0;      tgt[1]  = res_target_1;      tgt[2]  = res_target_2;
        ptgt[0] = res_pred_target_0; ptgt[1] = res_pred_target_1; ptgt[2] = res_pred_target_2;
        gh[0]   = res_ghist_0;       gh[1]   = res_ghist_1;       gh[2]   = res_ghist_2;
        tos[0]  = res_ras_tos_0;     tos[1]  = res_ras_tos_1;     tos[2]  = res_ras_tos_2;
        rob[0]  = res_rob_idx_0;     rob[1]  = res_rob_idx_1;     rob[2]  = res_rob_idx_2;
    end

    // Ages wrap modulo 2^ROB_IDX_W relative to the live head. The squash age
    // is re-derived every cycle, because the head moves while we recover.
    logic [ROB_IDX_W-1:0] age [3];
    logic [ROB_IDX_W-1:0] squash_age;
    logic [2:0]           elig, mis;
    logic [size-1:0]      cpc [3];

    always_comb begin
        squash_age = squash_idx_q - rob_head_i;
        for (int k = 0; k < 3; k++) begin
            age[k]  = rob[k] - rob_head_i;
            elig[k] = v[k] && (state_q == IDLE || age[k] < squash_age);
            mis[k]  = br[k] ? (tk[k] != ptk[k]) : (jr[k] && (tgt[k] != ptgt[k]));
            cpc[k]  = (jr[k] || tk[k]) ? tgt[k] : pc[k] + size'(4);
        end
    end

    // Oldest eligible mispredict. The strict '<' keeps the lower slot on an age tie.
    logic                 win_found;
    logic [1:0]           win_k;
    logic [ROB_IDX_W-1:0] win_age;

    always_comb begin
        win_found = 1'b0;
        win_k     = 2'd0;
        win_age   = '0;
        for (int k = 0; k < 3; k++) begin
            if (elig[k] && mis[k] && (!win_found || age[k] < win_age)) begin
                win_found = 1'b1;
                win_k     = 2'(k);
                win_age   = age[k];
            end
        end
    end

    // Slots strictly younger than the winner are on the wrong path.
    logic [2:0] keep;
    logic [1:0] n_upd;

    always_comb begin
        keep  = '0;
        n_upd = '0;
        for (int k = 0; k < 3; k++) begin
            keep[k] = elig[k] && (!win_found || age[k] <= win_age);
            n_upd   = n_upd + 2'(keep[k] && (br[k] || jr[k]));
        end
    end

    // FSM: state register / next state / outputs.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = RECOVER;
            RECOVER: if (!win_found && flush_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        recovering_o = (state_q == RECOVER);
    end

    always_ff @(posedge clk) begin
        if (reset)          squash_idx_q <= '0;
        else if (win_found) squash_idx_q <= rob[win_k];
    end

    // Registered update / redirect outputs. Data fields are zero when their valid bit is low.
    logic [2:0]      upd_v_q, mis_q, jv_q;
    logic [size-1:0] uppc_q [3], cpc_q [3], jpc_q [3];
    logic [GW-1:0]   gh_q [3];
    logic            ras_en_q, redir_v_q;
    logic [2:0]      ras_tos_q;
    logic [size-1:0] redir_pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_v_q <= '0; mis_q <= '0; jv_q <= '0;
            for (int k = 0; k < 3; k++) begin
                uppc_q[k] <= '0; cpc_q[k] <= '0; jpc_q[k] <= '0; gh_q[k] <= '0;
            end
            ras_en_q <= 1'b0; ras_tos_q <= '0; redir_v_q <= 1'b0; redir_pc_q <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                upd_v_q[k] <= keep[k] && br[k];
                jv_q[k]    <= keep[k] && jr[k];
                mis_q[k]   <= keep[k] && mis[k];
                uppc_q[k]  <= (keep[k] && br[k]) ? pc[k] : '0;
                gh_q[k]    <= (keep[k] && br[k]) ? gh[k] : '0;
                jpc_q[k]   <= (keep[k] && jr[k]) ? pc[k] : '0;
                cpc_q[k]   <= (keep[k] && (br[k] || jr[k])) ? cpc[k] : '0;
            end
            redir_v_q  <= win_found;
            redir_pc_q <= win_found ? cpc[win_k] : '0;
            ras_en_q   <= win_found;
            ras_tos_q  <= win_found ? tos[win_k] : '0;
        end
    end

    assign update_prediction_valid_o_0 = upd_v_q[0];
    assign update_prediction_valid_o_1 = upd_v_q[1];
    assign update_prediction_valid_o_2 = upd_v_q[2];
    assign update_prediction_pc_0      = uppc_q[0];
    assign update_prediction_pc_1      = uppc_q[1];
    assign update_prediction_pc_2      = uppc_q[2];
    assign misprediction_0             = mis_q[0];
    assign misprediction_1             = mis_q[1];
    assign misprediction_2             = mis_q[2];
    assign update_global_history_0     = gh_q[0];
    assign update_global_history_1     = gh_q[1];
    assign update_global_history_2     = gh_q[2];
    assign correct_pc_0                = cpc_q[0];
    assign correct_pc_1                = cpc_q[1];
    assign correct_pc_2                = cpc_q[2];
    assign jalr_update_valid_0         = jv_q[0];
    assign jalr_update_valid_1         = jv_q[1];
    assign jalr_update_valid_2         = jv_q[2];
    assign jalr_update_prediction_pc_0 = jpc_q[0];
    assign jalr_update_prediction_pc_1 = jpc_q[1];
    assign jalr_update_prediction_pc_2 = jpc_q[2];
    assign ras_restore_en_o            = ras_en_q;
    assign ras_restore_tos_o           = ras_tos_q;
    assign redirect_valid_o            = redir_v_q;
    assign redirect_pc_o               = redir_pc_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] pb_q, pm_q;
    logic [32:0] pb_sum;

    always_comb begin
        pb_sum = {1'b0, pb_q} + 33'(n_upd);
    end

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            pb_q <= '0;
            pm_q <= '0;
        end else begin
            pb_q <= pb_sum[32] ? '1 : pb_sum[31:0];
            if (win_found && pm_q != '1) pm_q <= pm_q + 32'd1;
        end
    end

    assign perf_branches_o = pb_q;
    assign perf_mispred_o  = pm_q;
`else
    logic unused_perf;
    assign unused_perf     = ^n_upd;
    assign perf_branches_o = '0;
    assign perf_mispred_o  = '0;
`endif

endmodule
